// File: rtl/network_send.sv
// network_send: buffers one packet from the transport send stage and frames
// it to the link stage as dst, src, len, payload[, checksum] over valid/ready.
// Optional feature macro: NETSEND_CSUM_EN adds the two's-complement checksum
// trailer byte (frame = len+4 bytes); without it the frame is len+3 bytes.
module network_send #(
  parameter int MAX_LEN = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] my_addr,
  input  logic [7:0] dest_addr,
  input  logic       sending,
  input  logic [7:0] packetIn,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       overflow
);

  localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

`ifdef NETSEND_CSUM_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, COLLECT = 3'd1, DROP = 3'd2, HDR_DST = 3'd3,
    HDR_SRC = 3'd4, HDR_LEN = 3'd5, PAYLOAD = 3'd6, CSUM = 3'd7
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, COLLECT = 3'd1, DROP = 3'd2, HDR_DST = 3'd3,
    HDR_SRC = 3'd4, HDR_LEN = 3'd5, PAYLOAD = 3'd6
  } state_t;
`endif

  state_t        state_r;
  logic [7:0]    buf_r [MAX_LEN];
  logic [7:0]    wptr_r;
  logic [7:0]    rptr_r;
  logic [7:0]    len_r;
  logic [7:0]    dst_r;
  logic          tx_valid_r;
  logic [7:0]    tx_data_r;
  logic          busy_r;
  logic          overflow_r;

  logic          xfer_s;
  logic          buf_we_s;
  logic          last_s;
  logic [AW-1:0] wr_idx_s;
  logic [AW-1:0] rd_idx_s;

`ifdef NETSEND_CSUM_EN
  logic [7:0]    csum_r;

  // Trailer byte that makes the 8-bit sum of the whole frame zero.
  function automatic logic [7:0] csum_trailer(input logic [7:0] sum);
    return ~sum + 8'd1;
  endfunction
`endif

  assign tx_valid = tx_valid_r;
  assign tx_data  = tx_data_r;
  assign busy     = busy_r;
  assign overflow = overflow_r;

  // Handshake, buffer write enable and prefetch address for the next payload byte.
  always_comb begin
    xfer_s   = tx_valid_r & tx_ready;
    buf_we_s = 1'b0;
    wr_idx_s = AW'(wptr_r);
    rd_idx_s = AW'(rptr_r + 8'd1);
    last_s   = (rptr_r == (len_r - 8'd1));
    case (state_r)
      IDLE: begin
        buf_we_s = sending;
        wr_idx_s = '0;
      end
      COLLECT: begin
        if (sending && (wptr_r < MAX_LEN_B)) begin
          buf_we_s = 1'b1;
        end else begin
          buf_we_s = 1'b0;
        end
      end
      HDR_LEN: rd_idx_s = '0;
      default: buf_we_s = 1'b0;
    endcase
  end

  // Packet buffer storage; contents need no reset since len gates every read.
  always_ff @(posedge clk) begin
    if (buf_we_s) begin
      buf_r[wr_idx_s] <= packetIn;
    end
  end

`ifdef NETSEND_CSUM_EN
  // Running frame sum, accumulated on every accepted byte and cleared when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum_r <= 8'd0;
    end else if (state_r == IDLE) begin
      csum_r <= 8'd0;
    end else if (xfer_s) begin
      csum_r <= csum_r + tx_data_r;
    end
  end
`endif

  // Framer state machine; tx byte is preloaded so outputs stay registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      wptr_r     <= 8'd0;
      rptr_r     <= 8'd0;
      len_r      <= 8'd0;
      dst_r      <= 8'd0;
      tx_valid_r <= 1'b0;
      tx_data_r  <= 8'd0;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (sending) begin
            dst_r   <= dest_addr;
            wptr_r  <= 8'd1;
            busy_r  <= 1'b1;
            state_r <= COLLECT;
          end
        end
        COLLECT: begin
          if (sending) begin
            if (wptr_r < MAX_LEN_B) begin
              wptr_r <= wptr_r + 8'd1;
            end else begin
              overflow_r <= 1'b1;
              state_r    <= DROP;
            end
          end else begin
            len_r      <= wptr_r;
            rptr_r     <= 8'd0;
            tx_valid_r <= 1'b1;
            tx_data_r  <= dst_r;
            state_r    <= HDR_DST;
          end
        end
        DROP: begin
          if (!sending) begin
            wptr_r  <= 8'd0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        HDR_DST: begin
          if (xfer_s) begin
            tx_data_r <= my_addr;
            state_r   <= HDR_SRC;
          end
        end
        HDR_SRC: begin
          if (xfer_s) begin
            tx_data_r <= len_r;
            state_r   <= HDR_LEN;
          end
        end
        HDR_LEN: begin
          if (xfer_s) begin
            tx_data_r <= buf_r[rd_idx_s];
            state_r   <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (xfer_s) begin
            if (last_s) begin
`ifdef NETSEND_CSUM_EN
              tx_data_r  <= csum_trailer(csum_r + tx_data_r);
              state_r    <= CSUM;
`else
              tx_valid_r <= 1'b0;
              tx_data_r  <= 8'd0;
              busy_r     <= 1'b0;
              wptr_r     <= 8'd0;
              rptr_r     <= 8'd0;
              state_r    <= IDLE;
`endif
            end else begin
              rptr_r    <= rptr_r + 8'd1;
              tx_data_r <= buf_r[rd_idx_s];
            end
          end
        end
`ifdef NETSEND_CSUM_EN
        CSUM: begin
          if (xfer_s) begin
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'd0;
            busy_r     <= 1'b0;
            wptr_r     <= 8'd0;
            rptr_r     <= 8'd0;
            state_r    <= IDLE;
          end
        end
`endif
        default: begin
          tx_valid_r <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_network_send.sv
// Self-checking bench for network_send: scoreboard of expected frame bytes,
// one task per scenario. Works with or without NETSEND_CSUM_EN.
module tb_network_send;
  localparam int MAX_LEN = 4;
`ifdef NETSEND_CSUM_EN
  localparam int OVH = 4;
`else
  localparam int OVH = 3;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] my_addr;
  logic [7:0] dest_addr;
  logic       sending;
  logic [7:0] packetIn;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       busy;
  logic       overflow;

  int checks = 0;
  int failures = 0;
  logic [7:0] pkt_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int   n_valid;
  int   stall_err;
  logic busy_end;

  always #5 clk = ~clk;

  network_send #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .reset(reset), .my_addr(my_addr), .dest_addr(dest_addr),
    .sending(sending), .packetIn(packetIn), .tx_ready(tx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .busy(busy), .overflow(overflow)
  );

  // Stream pkt_q into the DUT and push the expected frame onto the scoreboard.
  task automatic send_pkt(input logic [7:0] dst, input logic [7:0] src);
`ifdef NETSEND_CSUM_EN
    logic [7:0] sum;
    sum = dst + src + 8'(pkt_q.size());
`endif
    my_addr = src;
    exp_q.push_back(dst);
    exp_q.push_back(src);
    exp_q.push_back(8'(pkt_q.size()));
    for (int i = 0; i < pkt_q.size(); i++) begin
      @(posedge clk); #1;
      sending   = 1'b1;
      packetIn  = pkt_q[i];
      dest_addr = (i == 0) ? dst : ~dst;
      exp_q.push_back(pkt_q[i]);
`ifdef NETSEND_CSUM_EN
      sum = sum + pkt_q[i];
`endif
    end
    @(posedge clk); #1;
    sending  = 1'b0;
    packetIn = 8'd0;
`ifdef NETSEND_CSUM_EN
    exp_q.push_back(~sum + 8'd1);
`endif
    pkt_q.delete();
  endtask

  // Collect accepted bytes until tx_valid falls; mode 1 = ready every 3rd cycle.
  task automatic capture(input int mode, input int budget, output int timed_out);
    int cyc;
    logic seen, done, pv, pr;
    logic [7:0] pd;
    got_q.delete();
    n_valid = 0; stall_err = 0; busy_end = 1'b1;
    seen = 1'b0; done = 1'b0; pv = 1'b0; pr = 1'b0; pd = 8'd0; cyc = 0;
    while (!done && cyc < budget) begin
      @(posedge clk); #1;
      tx_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      cyc++;
      @(negedge clk);
      if (tx_valid) begin
        seen = 1'b1;
        n_valid++;
        if (pv && !pr && tx_data !== pd) stall_err++;
        if (tx_ready) got_q.push_back(tx_data);
      end else if (seen) begin
        if (pv && !pr) stall_err++;
        busy_end = busy;
        done = 1'b1;
      end
      pv = tx_valid; pr = tx_ready; pd = tx_data;
    end
    timed_out = done ? 0 : 1;
    tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    int spurious;
    reset = 1'b0; tx_ready = 1'b1; sending = 1'b0; packetIn = 8'd0;
    my_addr = 8'd0; dest_addr = 8'd0;
    #12;
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    checks++; if (tx_data !== 8'd0) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    reset = 1'b1;
    spurious = 0;
    repeat (4) begin
      @(negedge clk);
      if (tx_valid !== 1'b0 || busy !== 1'b0) spurious++;
    end
    checks++; if (spurious != 0) begin failures++; $display("FAIL reset_release_quiet got=%0d exp=0", spurious); end
  endtask

  task automatic test_frame(input string name, input int mode);
    int to;
    logic [7:0] e, g;
    int len;
    len = pkt_q.size();
    capture_after_send: begin
      send_pkt(8'h02, 8'h01);
    end
    capture(mode, 300, to);
    checks++; if (to != 0) begin failures++; $display("FAIL %s_timeout got=%0d exp=0", name, to); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        failures++; $display("FAIL %s_missing_byte got=none exp=%h", name, e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin failures++; $display("FAIL %s_byte got=%h exp=%h", name, g, e); end
      end
    end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL %s_extra_bytes got=%0d exp=0", name, got_q.size()); end
    checks++; if (busy_end !== 1'b0) begin failures++; $display("FAIL %s_busy_end got=%b exp=0", name, busy_end); end
    checks++; if (stall_err != 0) begin failures++; $display("FAIL %s_stall_stable got=%0d exp=0", name, stall_err); end
    if (mode == 0) begin
      checks++; if (n_valid != len + OVH) begin failures++; $display("FAIL %s_duration got=%0d exp=%0d", name, n_valid, len + OVH); end
    end
  endtask

  task automatic test_basic();
    pkt_q = '{8'h44, 8'h00};
    test_frame("basic", 0);
  endtask

  task automatic test_stall();
    pkt_q = '{8'h44, 8'h00};
    test_frame("stall", 1);
  endtask

  task automatic test_single();
    int to;
    logic [7:0] e, g;
    pkt_q = '{8'hFF};
    send_pkt(8'h00, 8'h00);
    capture(0, 100, to);
    checks++; if (to != 0) begin failures++; $display("FAIL single_timeout got=%0d exp=0", to); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        failures++; $display("FAIL single_missing_byte got=none exp=%h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin failures++; $display("FAIL single_byte got=%h exp=%h", g, e); end
      end
    end
    checks++; if (n_valid != 1 + OVH) begin failures++; $display("FAIL single_duration got=%0d exp=%0d", n_valid, 1 + OVH); end
  endtask

  task automatic test_max_len();
    int to;
    logic [7:0] e, g;
    pkt_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send_pkt(8'h5A, 8'h3C);
    capture(0, 100, to);
    checks++; if (to != 0) begin failures++; $display("FAIL maxlen_timeout got=%0d exp=0", to); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        failures++; $display("FAIL maxlen_missing_byte got=none exp=%h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin failures++; $display("FAIL maxlen_byte got=%h exp=%h", g, e); end
      end
    end
    checks++; if (n_valid != MAX_LEN + OVH) begin failures++; $display("FAIL maxlen_duration got=%0d exp=%0d", n_valid, MAX_LEN + OVH); end
  endtask

  task automatic test_overflow();
    logic [6:0] ovf_seen;
    int vcount;
    ovf_seen = 7'd0; vcount = 0;
    dest_addr = 8'h77; my_addr = 8'h11;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      sending = 1'b1; packetIn = 8'(8'h10 + i);
      @(negedge clk);
      ovf_seen[i] = overflow;
      if (tx_valid) vcount++;
    end
    @(posedge clk); #1;
    sending = 1'b0; packetIn = 8'd0;
    @(negedge clk);
    ovf_seen[6] = overflow;
    if (tx_valid) vcount++;
    repeat (6) begin
      @(negedge clk);
      if (tx_valid || overflow) vcount++;
    end
    checks++; if (ovf_seen !== 7'b010_0000) begin failures++; $display("FAIL overflow_pulse got=%b exp=0100000", ovf_seen); end
    checks++; if (vcount != 0) begin failures++; $display("FAIL overflow_no_frame got=%0d exp=0", vcount); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL overflow_busy got=%b exp=0", busy); end
    pkt_q = '{8'h9C, 8'h3E};
    test_frame("after_overflow", 0);
  endtask

  task automatic test_reset_mid();
    int cnt, cyc, spurious;
    pkt_q = '{8'h10, 8'h20, 8'h30};
    send_pkt(8'h05, 8'h06);
    exp_q.delete();
    cnt = 0; cyc = 0;
    while (cnt < 4 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (tx_valid) cnt++;
    end
    checks++; if (cnt != 4) begin failures++; $display("FAIL midreset_reach_payload got=%0d exp=4", cnt); end
    checks++; if (tx_data !== 8'h10) begin failures++; $display("FAIL midreset_payload_byte got=%h exp=10", tx_data); end
    #1 reset = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid_drop got=%b exp=0", tx_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    #20 reset = 1'b1;
    spurious = 0;
    repeat (5) begin
      @(negedge clk);
      if (tx_valid !== 1'b0) spurious++;
    end
    checks++; if (spurious != 0) begin failures++; $display("FAIL midreset_no_resume got=%0d exp=0", spurious); end
    pkt_q = '{8'hE7, 8'h42};
    test_frame("after_midreset", 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_single();
    test_max_len();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/network_send.md
# network_send

Network-layer framer that sits directly downstream of the transport send stage. It captures the byte stream the transport stage emits while `sending` is high and buffers one packet. It then transmits a framed packet to the physical/link stage over a valid/ready byte handshake: destination, source, length, payload, and an optional checksum.

## Interface
- `MAX_LEN`, 64: maximum payload bytes per packet (1..255); sets buffer depth.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `my_addr`  in  8  local node address, sent as the source byte.
- `dest_addr`  in  8  destination address; sampled on the first payload byte of each packet.
- `sending`  in  1  from transport stage; high on every cycle a payload byte is presented.
- `packetIn`  in  8  payload byte; valid on each cycle `sending` is high.
- `tx_ready`  in  1  link stage accepts `tx_data` this cycle.
- `tx_valid`  out  1  `tx_data` holds a frame byte.
- `tx_data`  out  8  frame byte.
- `busy`  out  1  high in every state except IDLE.
- `overflow`  out  1  one-cycle pulse when a packet is dropped for exceeding `MAX_LEN`.

## Operation
- **Buffer:** `MAX_LEN` x 8 register/RAM buffer, write pointer `wptr` and read pointer `rptr`, each 8 bits.
- **States:** IDLE, COLLECT, DROP, HDR_DST, HDR_SRC, HDR_LEN, PAYLOAD, CSUM.
- **IDLE:**
  - On `sending`=1: write `packetIn` to buf[0], latch `dest_addr`, set `wptr`=1, go to COLLECT.
- **COLLECT:**
  - `sending`=1 and `wptr`<`MAX_LEN`: write buf[`wptr`] and increment `wptr`.
  - `sending`=1 and `wptr`=`MAX_LEN`: pulse `overflow`, go to DROP.
  - `sending`=0: latch `len`=`wptr`, clear `rptr`, go to HDR_DST.
- **DROP:**
  - Discard bytes until `sending`=0, then go to IDLE.
  - No frame bytes are emitted for the dropped packet.
- **Transmit states:**
  - HDR_DST emits the latched destination, HDR_SRC emits `my_addr` (sampled live), HDR_LEN emits `len`.
  - PAYLOAD emits buf[`rptr`], incrementing `rptr` on each transfer.
  - PAYLOAD exits to CSUM (or to IDLE when checksum is compiled out) on the transfer with `rptr`=`len`-1.
- **Advance rule:** each transmit state advances only on a transfer (`tx_valid`&`tx_ready`).
- **Checksum:**
  - `csum` is an 8-bit running sum, mod 256, of dst, src, len and all payload bytes.
  - It accumulates at each transfer.
  - CSUM emits (~`csum`+1)&8'hFF, so the 8-bit sum of the whole frame, trailer included, is 0.
- **`sending` outside IDLE/COLLECT/DROP:** ignored. Those bytes are lost, and `overflow` does not pulse. Upstream must honour `busy`.
- **Reset mid-operation:** the frame in progress is abandoned immediately. No partial frame resumes after reset release.

## Timing
- **Reset values:** state=IDLE, `tx_valid`=0, `tx_data`=0, `busy`=0, `overflow`=0, pointers=0, `csum`=0.
- **`tx_valid` and `tx_data` are registered.** `tx_data` is stable while `tx_valid`=1 and `tx_ready`=0. `tx_valid` never drops without a transfer.
- **Frame start:** if `sending` falls (first low cycle = N), `tx_valid`=1 with the destination byte from cycle N+1.
- **Frame duration:** with `tx_ready` held 1, the frame takes `len`+4 consecutive cycles (`len`+3 without checksum).
- **End of frame:** `busy` falls the cycle after the last transfer. A new packet may start (`sending`=1) in that cycle.
- **`busy`:** rises the cycle after the first byte is captured.
- **`overflow`:** a single registered pulse, asserted the cycle after the offending byte.
- **Boundaries:**
  - `len`=`MAX_LEN` is legal.
  - A 1-byte packet is legal.
  - `tx_ready` toggling each cycle only stretches the frame; content is unchanged.

## Configuration
- `NETSEND_CSUM_EN` defined: the CSUM state and trailer byte are present, and the frame is `len`+4 bytes.
- Undefined: no CSUM state and no checksum adder. The frame is `len`+3 bytes and ends after the last payload byte.

## Test plan
- Reset asserted with `tx_ready`=1 → all outputs 0, state IDLE; release shows no spurious `tx_valid`.
- `my_addr`=8'h01, `dest_addr`=8'h02, payload 8'h44,8'h00 (3 cycles of `sending` minus one, i.e. 2 bytes), `tx_ready`=1 → frame 02,01,02,44,00,B7; `busy` low one cycle after B7.
- Same packet with `tx_ready` high every 3rd cycle → identical byte sequence; `tx_data` stable while stalled.
- Single payload byte 8'hFF, dst 8'h00, src 8'h00 → frame 00,00,01,FF,00 (checksum 8'h00).
- `MAX_LEN`=4, stream 6 bytes → `overflow` one pulse after byte 5, no `tx_valid` for that packet; the next 2-byte packet frames correctly.
- Assert `reset` low during PAYLOAD → `tx_valid` drops immediately; after release, a new packet produces a clean frame with correct checksum.
